// File: rtl/adc16_pkg.sv
// rtl/adc16_pkg.sv - shared FSM encoding and widths for the adc16_rx serial ADC receiver
package adc16_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 16;
  localparam int EDGE_W = 5;
  localparam int ACC_W  = WORD_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONV  = 3'd1,
    ST_SETUP = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/adc16_sck_gen.sv
// rtl/adc16_sck_gen.sv - serial clock generator: half-period divider, rise/fall pulses, rising edge count
module adc16_sck_gen
  import adc16_pkg::*;
#(
  parameter int SCK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  output logic              o_sck,
  output logic              o_rise,
  output logic              o_fall,
  output logic [EDGE_W-1:0] o_edge_cnt
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCK_DIV - 1);

  logic [CNT_W-1:0]  r_div;
  logic              r_sck;
  logic [EDGE_W-1:0] r_edge_cnt;
  logic              w_tick;

  // rise/fall flag the cycle whose closing clk edge flips sck
  assign w_tick     = i_en && (r_div == DIV_LAST);
  assign o_rise     = w_tick && !r_sck;
  assign o_fall     = w_tick && r_sck;
  assign o_sck      = r_sck;
  assign o_edge_cnt = r_edge_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_sck      <= 1'b0;
      r_edge_cnt <= '0;
    end else if (!i_en) begin
      r_div      <= '0;
      r_sck      <= 1'b0;
      r_edge_cnt <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_sck <= !r_sck;
      end
      if (o_rise) begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc16_rx.sv
// rtl/adc16_rx.sv - serial ADC receiver: convst, cs/sck framing and 16-bit capture
// Optional ADC16_RX_AVG_EN: report the mean of every four conversions.
module adc16_rx
  import adc16_pkg::*;
#(
  parameter int SCK_DIV   = 2,
  parameter int CONV_CYC  = 8,
  parameter int SETUP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_state,
  input  logic              start,
  input  logic              sdo,
  output logic              convst,
  output logic              cs,
  output logic              sck,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] r_data_out;
  logic              r_data_valid;

  logic              w_sck_en;
  logic              w_sck;
  logic              w_sck_rise;
  logic              w_sck_fall;
  logic [EDGE_W-1:0] w_edge_cnt;
  logic              w_last;

  assign w_sck_en = key_state && (r_state == ST_SHIFT);

  adc16_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_sck_en),
    .o_sck      (w_sck),
    .o_rise     (w_sck_rise),
    .o_fall     (w_sck_fall),
    .o_edge_cnt (w_edge_cnt)
  );

  // SHIFT ends on the falling edge that closes the half-period after the 16th rise
  assign w_last = w_sck_fall && (w_edge_cnt == EDGE_W'(WORD_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!key_state) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_state_next = ST_CONV;
        ST_CONV:  if (r_cnt == CONV_LAST) w_state_next = ST_SETUP;
        ST_SETUP: if (r_cnt == SETUP_LAST) w_state_next = ST_SHIFT;
        ST_SHIFT: if (w_last) w_state_next = ST_DONE;
        ST_DONE:  w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    convst = (r_state == ST_CONV);
    cs     = !((r_state == ST_SETUP) || (r_state == ST_SHIFT));
    busy   = (r_state != ST_IDLE);
  end

  assign sck        = w_sck;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((w_state_next != r_state) || !((r_state == ST_CONV) || (r_state == ST_SETUP))) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef ADC16_RX_AVG_EN
  logic [ACC_W-1:0] r_acc;
  logic [1:0]       r_avg_cnt;
  logic [ACC_W-1:0] w_acc_sum;

  assign w_acc_sum = r_acc + ACC_W'(r_shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_acc        <= '0;
      r_avg_cnt    <= '0;
    end else if (!key_state) begin
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_acc        <= '0;
      r_avg_cnt    <= '0;
    end else begin
      r_data_valid <= 1'b0;
      if (w_sck_rise) begin
        r_shift <= {r_shift[WORD_W-2:0], sdo};
      end
      if (r_state == ST_DONE) begin
        if (r_avg_cnt == 2'd3) begin
          r_data_out   <= w_acc_sum[ACC_W-1:2];
          r_data_valid <= 1'b1;
          r_acc        <= '0;
          r_avg_cnt    <= '0;
        end else begin
          r_acc     <= w_acc_sum;
          r_avg_cnt <= r_avg_cnt + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else if (!key_state) begin
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (w_sck_rise) begin
        r_shift <= {r_shift[WORD_W-2:0], sdo};
      end
      if (r_state == ST_DONE) begin
        r_data_out   <= r_shift;
        r_data_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc16_rx.sv
// tb/tb_adc16_rx.sv - self-checking bench for adc16_rx with an ADC model and data scoreboard
module tb_adc16_rx;

  localparam int SCK_DIV   = 2;
  localparam int CONV_CYC  = 8;
  localparam int SETUP_CYC = 4;
  localparam int LATENCY   = CONV_CYC + SETUP_CYC + 32 * SCK_DIV + 1;
  localparam int CS_LOW    = SETUP_CYC + 32 * SCK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_state = 1'b1;
  logic        start = 1'b0;
  logic        sdo = 1'b0;
  logic        convst;
  logic        cs;
  logic        sck;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;

  adc16_rx #(
    .SCK_DIV   (SCK_DIV),
    .CONV_CYC  (CONV_CYC),
    .SETUP_CYC (SETUP_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_state  (key_state),
    .start      (start),
    .sdo        (sdo),
    .convst     (convst),
    .cs         (cs),
    .sck        (sck),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ADC model: MSB presented when cs falls, next bit after every sck falling edge
  logic [15:0] adc_word = 16'h0000;
  logic [15:0] adc_sr = 16'h0000;
  always @(negedge cs) begin
    adc_sr = adc_word;
    sdo = adc_sr[15];
  end
  always @(negedge sck) begin
    adc_sr = {adc_sr[14:0], 1'b0};
    sdo = adc_sr[15];
  end

  typedef struct {
    logic [15:0] data;
    int          t0;
  } sb_t;
  sb_t sb_q[$];

  int   rise_cnt = 0;
  int   cs_low_cnt = 0;
  int   conv_cnt = 0;
  logic sck_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!cs) cs_low_cnt++;
      if (convst) conv_cnt++;
      if (sck && !sck_prev) rise_cnt++;
      if (data_valid) begin
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_valid: data_out=0x%0h with no transfer pending (t=%0t)", data_out, $time);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("data_out", int'(data_out), int'(e.data));
          check("latency", cyc - e.t0, LATENCY);
          check("sck_rises", rise_cnt, 16);
          check("cs_low_cycles", cs_low_cnt, CS_LOW);
          check("convst_cycles", conv_cnt, CONV_CYC);
        end
      end
    end
    sck_prev = sck;
  end

  task automatic pulse_start(input logic [15:0] word, input logic push, input logic [15:0] exp);
    adc_word = word;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rise_cnt = 0;
    cs_low_cnt = 0;
    conv_cnt = 0;
    if (push) sb_q.push_back('{exp, cyc});
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout_busy", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] word;
    logic        exp_valid;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  initial begin
`ifdef ADC16_RX_AVG_EN
    vecs.push_back('{16'h0010, 1'b0, 16'h0000});
    vecs.push_back('{16'h0020, 1'b0, 16'h0000});
    vecs.push_back('{16'h0030, 1'b0, 16'h0000});
    vecs.push_back('{16'h0040, 1'b1, 16'h0028});
    vecs.push_back('{16'hFFFF, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFF, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFF, 1'b0, 16'h0000});
    vecs.push_back('{16'hFFFF, 1'b1, 16'hFFFF});
`else
    vecs.push_back('{16'hA5C3, 1'b1, 16'hA5C3});
    vecs.push_back('{16'h0000, 1'b1, 16'h0000});
    vecs.push_back('{16'hFFFF, 1'b1, 16'hFFFF});
    vecs.push_back('{16'h8001, 1'b1, 16'h8001});
    vecs.push_back('{16'h1234, 1'b1, 16'h1234});
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", int'(cs), 1);
    check("rst_sck", int'(sck), 0);
    check("rst_convst", int'(convst), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      pulse_start(vecs[i].word, vecs[i].exp_valid, vecs[i].exp);
      wait_idle(200);
    end

`ifndef ADC16_RX_AVG_EN
    // start repeated mid-transfer and on the DONE cycle must be ignored
    pulse_start(16'h5A3C, 1'b1, 16'h5A3C);
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      start = (i == 9) || (i == 40) || (i == 76);
      if (i == 77) check("done_start_busy_e77", int'(busy), 0);
      if (i == 78) check("done_start_busy_e78", int'(busy), 0);
    end
    repeat (100) @(posedge clk);
    #1;
`endif

    // key_state dropped on the 8th sck rising edge
    begin
      int   n = 0;
      int   k = 0;
      logic p = 1'b0;
      pulse_start(16'hC0DE, 1'b0, 16'h0000);
      while (n < 8 && k < 300) begin
        @(posedge clk);
        #1;
        if (sck && !p) n++;
        p = sck;
        k++;
      end
      check("key_drop_reached_8_rises", n, 8);
      key_state = 1'b0;
      @(posedge clk);
      #1;
      check("key_drop_cs", int'(cs), 1);
      check("key_drop_sck", int'(sck), 0);
      check("key_drop_convst", int'(convst), 0);
      check("key_drop_data_out", int'(data_out), 0);
      check("key_drop_busy", int'(busy), 0);
      repeat (3) @(posedge clk);
      #1 key_state = 1'b1;
      repeat (100) @(posedge clk);
      #1;
    end
`ifndef ADC16_RX_AVG_EN
    pulse_start(16'h6E21, 1'b1, 16'h6E21);
    wait_idle(200);
`endif

    // asynchronous reset in the middle of SHIFT
    pulse_start(16'h3C3C, 1'b0, 16'h0000);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs", int'(cs), 1);
    check("mid_rst_sck", int'(sck), 0);
    check("mid_rst_convst", int'(convst), 0);
    check("mid_rst_data_out", int'(data_out), 0);
    check("mid_rst_data_valid", int'(data_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    check("mid_rst_busy_after", int'(busy), 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
